// File: rtl/seg_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_rx_pkg
//  Description : Shared constants for the seven-segment scan receiver.
//                Holds the 16 active-high gfedcba hex patterns, the segment
//                bit positions, the digit count and a one-hot to index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_rx_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment bit positions inside the 8-bit segment bus
  localparam int SEG_DP = 7;
  localparam int SEG_G  = 6;
  localparam int SEG_F  = 5;
  localparam int SEG_E  = 4;
  localparam int SEG_D  = 3;
  localparam int SEG_C  = 2;
  localparam int SEG_B  = 1;
  localparam int SEG_A  = 0;

  // Active-high gfedcba patterns for the hex glyphs
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Position of the active bit of a one-hot select (caller guarantees one-hot)
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    if (oh[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_to_hex
//  Description : Combinational seven-segment to hex decoder.
//                pat_i : active-high gfedcba pattern
//                nib_o : decoded nibble (0 when not decodable)
//                bad_o : 1 when pattern is not one of the 16 hex glyphs
//                        (a blank digit is reported as bad)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_hex
  import seg_rx_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nib_o,
  output logic       bad_o
);

  always_comb begin
    nib_o = 4'h0;
    bad_o = 1'b0;
    case (pat_i)
      SEG_HEX_0: nib_o = 4'h0;
      SEG_HEX_1: nib_o = 4'h1;
      SEG_HEX_2: nib_o = 4'h2;
      SEG_HEX_3: nib_o = 4'h3;
      SEG_HEX_4: nib_o = 4'h4;
      SEG_HEX_5: nib_o = 4'h5;
      SEG_HEX_6: nib_o = 4'h6;
      SEG_HEX_7: nib_o = 4'h7;
      SEG_HEX_8: nib_o = 4'h8;
      SEG_HEX_9: nib_o = 4'h9;
      SEG_HEX_A: nib_o = 4'hA;
      SEG_HEX_B: nib_o = 4'hB;
      SEG_HEX_C: nib_o = 4'hC;
      SEG_HEX_D: nib_o = 4'hD;
      SEG_HEX_E: nib_o = 4'hE;
      SEG_HEX_F: nib_o = 4'hF;
      default:   bad_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_rx
//  Description : Receiver for a multiplexed 4-digit seven-segment scan bus.
//                Debounces each digit dwell, decodes it back to hex and
//                publishes complete 4-digit frames.
//  Ports       : clk, rst (sync, active-high)
//                seg_in[7:0]  scanned segments (bit7 dp, bits6:0 g..a)
//                sel_in[3:0]  digit selects (bit0 = rightmost digit)
//                digits[15:0] last frame, nibble i = digit i
//                bad[3:0]     per-digit undecodable flag of last frame
//                dp_out[3:0]  decimal points of last frame
//                frame_valid  one-cycle pulse on frame update
//                changed      frame differs from previous (with frame_valid)
//                stale        no digit accepted for TIMEOUT_CYC cycles
//  Options     : SEG_RX_DP_CAPTURE_EN - capture decimal points; when not
//                defined seg_in[7] is ignored and dp_out stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_rx
  import seg_rx_pkg::*;
#(
  parameter int STABLE_CYC     = 16,
  parameter int TIMEOUT_CYC    = 1_000_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_in,
  input  logic [3:0]  sel_in,
  output logic [15:0] digits,
  output logic [3:0]  bad,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        changed,
  output logic        stale
);

  localparam int CNT_W  = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE  = CNT_W'(STABLE_CYC - 2);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);
  localparam logic [IDLE_W-1:0] IDLE_PRE = IDLE_W'(TIMEOUT_CYC - 1);

  logic [7:0]                  seg_q;
  logic [3:0]                  sel_q;
  logic [11:0]                 prev_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDLE_W-1:0]           idle_q;
  logic [15:0]                 nbuf_q;
  logic [NUM_DIGITS-1:0]       badbuf_q, dpbuf_q, seen_q;

  logic [7:0]  seg_n;
  logic [3:0]  sel_n;
  logic        dp_n;
  logic [11:0] cur;
  logic        sel_ok, match, accept, timeout_hit;
  logic [1:0]  idx;
  logic [3:0]  idx_oh;
  logic [3:0]  dec_nib;
  logic        dec_bad;

  assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign sel_n = (SEL_ACTIVE_LOW != 0) ? ~sel_q : sel_q;

`ifdef SEG_RX_DP_CAPTURE_EN
  assign dp_n = seg_n[SEG_DP];
`else
  // dp is masked out of the compare and never buffered
  logic unused_dp;
  assign unused_dp = seg_n[SEG_DP];
  assign dp_n      = 1'b0;
`endif

  assign cur    = {sel_n, dp_n, seg_n[6:0]};
  assign sel_ok = (sel_n != 4'd0) && ((sel_n & (sel_n - 4'd1)) == 4'd0);
  assign match  = sel_ok && (cur == prev_q);
  // Fires only on the step into CNT_MAX, so once per dwell
  assign accept = match && (cnt_q == CNT_PRE);
  assign idx    = onehot_to_idx(sel_n);
  assign idx_oh = 4'b0001 << idx;
  assign timeout_hit = !accept && (idle_q == IDLE_PRE);

  always_comb begin
    cnt_d = cnt_q;
    if (!match)
      cnt_d = '0;
    else if (cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  seg7_to_hex u_dec (
    .pat_i (seg_n[6:0]),
    .nib_o (dec_nib),
    .bad_o (dec_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q       <= '0;
      sel_q       <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      idle_q      <= '0;
      nbuf_q      <= '0;
      badbuf_q    <= '0;
      dpbuf_q     <= '0;
      seen_q      <= '0;
      digits      <= '0;
      bad         <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      seg_q       <= seg_in;
      sel_q       <= sel_in;
      prev_q      <= cur;
      cnt_q       <= cnt_d;
      frame_valid <= 1'b0;

      if (accept) begin
        nbuf_q[{idx, 2'b00} +: 4] <= dec_nib;
        badbuf_q[idx]             <= dec_bad;
        dpbuf_q[idx]              <= dp_n;
      end

      if (accept)
        idle_q <= '0;
      else if (idle_q != IDLE_MAX)
        idle_q <= idle_q + 1'b1;

      if (seen_q == 4'hF) begin
        // Outputs take the buffers as they stood before this cycle's accept;
        // that accept is carried into the next frame.
        digits      <= nbuf_q;
        bad         <= badbuf_q;
        dp_out      <= dpbuf_q;
        frame_valid <= 1'b1;
        changed     <= ({nbuf_q, badbuf_q, dpbuf_q} != {digits, bad, dp_out});
        stale       <= 1'b0;
        seen_q      <= accept ? idx_oh : 4'd0;
      end else if (timeout_hit) begin
        stale  <= 1'b1;
        seen_q <= '0;
      end else if (accept) begin
        seen_q <= seen_q | idx_oh;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_rx
//  Description : Directed self-checking bench for seg_scan_rx
//                (STABLE_CYC=4, TIMEOUT_CYC=200, active-low seg and sel).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_in;
  logic [3:0]  sel_in;
  logic [15:0] digits;
  logic [3:0]  bad;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic        changed;
  logic        stale;

  int n_tot = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  logic last_changed = 1'b0;

`ifdef SEG_RX_DP_CAPTURE_EN
  localparam logic [3:0]  DP_BAD_EXP = 4'b0001;
  localparam logic [3:0]  DP_EXP     = 4'b0100;
  localparam logic        DP_CHG_EXP = 1'b1;
`else
  localparam logic [3:0]  DP_BAD_EXP = 4'b0000;
  localparam logic [3:0]  DP_EXP     = 4'b0000;
  localparam logic        DP_CHG_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  seg_scan_rx #(
    .STABLE_CYC     (4),
    .TIMEOUT_CYC    (200),
    .SEG_ACTIVE_LOW (1),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
    .digits      (digits),
    .bad         (bad),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .changed     (changed),
    .stale       (stale)
  );

  // Frame monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt       <= fv_cnt + 1;
      last_changed <= changed;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one digit (active-low select) with a raw segment byte for n cycles
  task automatic drive_digit(input int i, input logic [7:0] seg, input int n);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    @(negedge clk);
    sel_in = ~oh;
    seg_in = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic blank(input int n);
    @(negedge clk);
    sel_in = 4'hF;
    seg_in = 8'hFF;
    repeat (n - 1) @(negedge clk);
  endtask

  // Scan digit3..digit0 with raw (active-low) segment bytes
  task automatic scan4(input logic [7:0] s3, input logic [7:0] s2,
                       input logic [7:0] s1, input logic [7:0] s0, input int n);
    drive_digit(3, s3, n);
    drive_digit(2, s2, n);
    drive_digit(1, s1, n);
    drive_digit(0, s0, n);
    blank(6);
  endtask

  initial begin
    rst    = 1'b1;
    seg_in = 8'hFF;
    sel_in = 4'hF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_digits", digits, 16'h0);
    check("rst_bad",    {12'h0, bad}, 16'h0);
    check("rst_dp",     {12'h0, dp_out}, 16'h0);
    check("rst_fv",     {15'h0, frame_valid}, 16'h0);
    check("rst_chg",    {15'h0, changed}, 16'h0);
    check("rst_stale",  {15'h0, stale}, 16'h0);

    // 1,2,3,4
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    check("f1_count",  16'(fv_cnt), 16'd1);
    check("f1_digits", digits, 16'h1234);
    check("f1_bad",    {12'h0, bad}, 16'h0);
    check("f1_chg",    {15'h0, last_changed}, 16'h1);

    // Identical repeat
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    check("f2_count",  16'(fv_cnt), 16'd2);
    check("f2_chg",    {15'h0, last_changed}, 16'h0);

    // 3-cycle dwells never accept
    scan4(8'h92, 8'h82, 8'hF8, 8'h80, 3);
    check("glitch_count",  16'(fv_cnt), 16'd2);
    check("glitch_digits", digits, 16'h1234);
    // 5-cycle dwells accept: 5,6,7,8
    scan4(8'h92, 8'h82, 8'hF8, 8'h80, 5);
    check("f3_count",  16'(fv_cnt), 16'd3);
    check("f3_digits", digits, 16'h5678);
    check("f3_chg",    {15'h0, last_changed}, 16'h1);

    // Two active selects mid-scan: 9,A, blanking, then b,C
    drive_digit(3, 8'h90, 10);
    drive_digit(2, 8'h88, 10);
    @(negedge clk);
    sel_in = 4'b0011;
    seg_in = 8'h90;
    repeat (19) @(negedge clk);
    check("multi_count", 16'(fv_cnt), 16'd3);
    drive_digit(1, 8'h83, 10);
    drive_digit(0, 8'hC6, 10);
    blank(6);
    check("f4_count",  16'(fv_cnt), 16'd4);
    check("f4_digits", digits, 16'h9ABC);

    // Undecodable digit0 (normalized 0x80: dp only, segments blank)
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h7F, 10);
    check("f5_count",  16'(fv_cnt), 16'd5);
    check("f5_digits", digits, 16'h1230);
    check("f5_bad",    {12'h0, bad}, 16'h0001);
    check("f5_dp",     {12'h0, dp_out}, {12'h0, DP_BAD_EXP});
    check("f5_chg",    {15'h0, last_changed}, 16'h1);

    // Idle: stale not yet, then stale with held outputs
    blank(100);
    check("stale_early", {15'h0, stale}, 16'h0);
    blank(110);
    check("stale_set",    {15'h0, stale}, 16'h1);
    check("stale_digits", digits, 16'h1230);
    check("stale_count",  16'(fv_cnt), 16'd5);

    // Resume
    scan4(8'hF9, 8'hA4, 8'hB0, 8'h99, 10);
    check("f6_count",  16'(fv_cnt), 16'd6);
    check("f6_stale",  {15'h0, stale}, 16'h0);
    check("f6_digits", digits, 16'h1234);
    check("f6_bad",    {12'h0, bad}, 16'h0);
    check("f6_chg",    {15'h0, last_changed}, 16'h1);

    // Decimal point on digit2 only
    scan4(8'hF9, 8'h24, 8'hB0, 8'h99, 10);
    check("f7_count",  16'(fv_cnt), 16'd7);
    check("f7_digits", digits, 16'h1234);
    check("f7_dp",     {12'h0, dp_out}, {12'h0, DP_EXP});
    check("f7_chg",    {15'h0, last_changed}, {15'h0, DP_CHG_EXP});

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_rx.md
Name: seg_scan_rx

Overview:
- Receiving end of the team's multiplexed 4-digit seven-segment display interface, i.e. the `seg_out`/`sel` pins driven by the display scanner.
- Samples the scanned segment and digit-select lines and rejects ghosting during digit transitions.
- Decodes each digit pattern back to a hex nibble and assembles complete 4-digit frames.
- Used as an on-board or bench monitor so displayed counters (e.g. traffic-light countdown) can be checked or forwarded.

Parameters:
- STABLE_CYC, 16: consecutive identical samples required to accept a digit (min 2).
- TIMEOUT_CYC, 1_000_000: cycles without any acceptance before `stale` asserts.
- SEG_ACTIVE_LOW, 1: 1 = segment lines active-low (common anode).
- SEL_ACTIVE_LOW, 1: 1 = select lines active-low.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- seg_in  in  8  scanned segments; bit7 = dp, bits6:0 = g..a.
- sel_in  in  4  digit selects; bit0 = rightmost digit.
- digits  out  16  last frame, nibble i = digit i.
- bad  out  4  per-digit flag: pattern not decodable in last frame.
- dp_out  out  4  decimal points of last frame (see Optional Feature).
- frame_valid  out  1  one-cycle pulse when `digits`/`bad`/`dp_out` update.
- changed  out  1  valid with `frame_valid`: the new frame differs from the previous one.
- stale  out  1  no digit accepted for TIMEOUT_CYC cycles.

Behaviour:
- Input stage:
  - `seg_in` and `sel_in` are registered once, then normalized to active-high per the *_ACTIVE_LOW parameters.
- Select validity:
  - The normalized select must be one-hot.
  - Zero or multiple active bits = blanking: the stability counter clears and nothing is accepted.
- Stability:
  - Counter `cnt` increments while the (sel, seg[6:0]) pair equals the previous registered sample; it clears on any difference.
  - `cnt` saturates at STABLE_CYC-1.
  - Acceptance fires exactly once per dwell, in the cycle `cnt` transitions to STABLE_CYC-1.
- Accept:
  - The decoded nibble is written to `buf[idx]`, where idx = position of the select bit.
  - The bad flag is written to `badbuf[idx]` and `seen[idx]` is set.
  - Re-acceptance of an already-seen digit overwrites it.
- Decode (active-high gfedcba):
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=b, 39=C, 5E=d, 79=E, 71=F.
  - Any other pattern: nibble 0, bad=1.
  - A blank digit (00) counts as bad.
- Frame:
  - When `seen` = 1111, on the next cycle `digits`/`bad`/`dp_out` load from the buffers and `frame_valid` pulses.
  - `changed` = (new digits/bad/dp != held values).
  - `seen` clears, except for an acceptance in that same cycle, which sets its bit for the next frame; it is never lost.
- Latency:
  - Input edge to acceptance = 1 + STABLE_CYC cycles.
  - Final acceptance to `frame_valid` = 1 cycle.
- Timeout:
  - The idle counter resets on every acceptance.
  - On reaching TIMEOUT_CYC: `stale`=1 and `seen` cleared; held outputs are kept.
  - `stale` clears in the cycle `frame_valid` pulses.
- Reset:
  - All outputs 0, buffers 0, `seen` 0, counters 0.
  - Reset mid-frame discards partial data; the first frame after reset reports `changed`=1 whenever any field is non-zero.

Optional Feature:
- Macro SEG_RX_DP_CAPTURE_EN.
- Defined:
  - seg[7] is included in the stability compare.
  - The dp of each accepted digit is buffered and presented on `dp_out` with the frame, and contributes to `changed`.
- Undefined:
  - seg[7] is ignored entirely and `dp_out` is tied 0.

Decomposition:
- Package seg_rx_pkg:
  - the 16 segment pattern constants;
  - the segment bit-position constants (DP=7, G..A=6..0);
  - the digit-count constant (4).
- One combinational sub-module seg7_to_hex: 7-bit pattern in, 4-bit nibble + bad flag out.

Test Plan:
Bench uses STABLE_CYC=4, TIMEOUT_CYC=200, both ACTIVE_LOW=1.
- After reset, scan 1,2,3,4 (digit3..0), each held 10 cycles: sel E..7, seg C0-style inverted codes F9/A4/B0/99 -> `frame_valid` once, `digits`=16'h1234, `bad`=0, `changed`=1.
- Repeat the identical scan -> `frame_valid` with `changed`=0.
- Glitch: hold a pattern 3 cycles, then switch -> no acceptance; frame only after all 4 digits hold at least 5 cycles.
- Select 4'b1100 (two active) for 20 cycles mid-scan -> no acceptance; `seen` unaffected.
- Digit0 seg=8'h80 (undecodable) -> `bad`=4'b0001, digits[3:0]=0.
- Stop scanning for 200 cycles -> `stale`=1 and `digits` held; resume -> `stale` clears with the next `frame_valid`.
- With SEG_RX_DP_CAPTURE_EN: dp on digit2 only -> `dp_out`=4'b0100.
